// File: rtl/seq_div_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
// The master drives requests; the slave (divider) returns registered results.
interface seq_div_if #(
  parameter int DATAWIDTH = 8
);
  logic                            start;
  logic signed [2*DATAWIDTH-1:0]   dividend;
  logic signed [DATAWIDTH-1:0]     divisor;
  logic signed [DATAWIDTH-1:0]     quo;
  logic signed [DATAWIDTH-1:0]     rem;
  logic                            busy;
  logic                            done;
  logic                            ovf;
  logic                            dbz;

  modport master (
    output start, dividend, divisor,
    input  quo, rem, busy, done, ovf, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output quo, rem, busy, done, ovf, dbz
  );
endinterface

// File: rtl/seq_div.sv
// Multi-cycle signed divider: 2N-bit dividend by N-bit divisor, restoring
// shift-subtract on magnitudes, one quotient bit per clock, saturating quotient.
module seq_div #(
  parameter int DATAWIDTH = 8
) (
  input logic      Clk,
  input logic      rst,
  seq_div_if.slave bus
);
  localparam int N  = DATAWIDTH;
  localparam int W  = 2 * DATAWIDTH;
  localparam int CW = $clog2(W) + 1;

  // Quotient range limits in the (W+1)-bit signed domain used for the range check.
  localparam logic signed [W:0] Q_MAX = {{(W-N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W:0] Q_MIN = {{(W-N+2){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic [W-1:0] abs_wide(input logic [W-1:0] v);
    return v[W-1] ? -v : v;
  endfunction

  function automatic logic [N-1:0] abs_narrow(input logic [N-1:0] v);
    return v[N-1] ? -v : v;
  endfunction

  state_e          state_q, state_d;
  logic [W-1:0]    dvd_q, dvd_d;
  logic [N:0]      pr_q, pr_d;
  logic [N-1:0]    dsr_q, dsr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            dvd_neg_q, dvd_neg_d;
  logic            q_neg_q, q_neg_d;
  logic            zero_q, zero_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;
  logic [N:0]      shifted_s;
  logic signed [W:0] qs_s;

  // Next-state, datapath iteration and result formatting.
  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    pr_d      = pr_q;
    dsr_d     = dsr_q;
    cnt_d     = cnt_q;
    dvd_neg_d = dvd_neg_q;
    q_neg_d   = q_neg_q;
    zero_d    = zero_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    shifted_s = {pr_q[N-1:0], dvd_q[W-1]};
    qs_s      = q_neg_q ? -$signed({1'b0, dvd_q}) : $signed({1'b0, dvd_q});

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d     = abs_wide(bus.dividend);
          dsr_d     = abs_narrow(bus.divisor);
          dvd_neg_d = bus.dividend[W-1];
          q_neg_d   = bus.dividend[W-1] ^ bus.divisor[N-1];
          zero_d    = (bus.divisor == {N{1'b0}});
          cnt_d     = CW'(W);
          pr_d      = {(N+1){1'b0}};
          busy_d    = 1'b1;
          state_d   = CALC;
        end else begin
          state_d   = IDLE;
        end
      end
      CALC: begin
        // The dividend register doubles as the quotient shift register.
        if (shifted_s >= {1'b0, dsr_q}) begin
          pr_d  = shifted_s - {1'b0, dsr_q};
          dvd_d = {dvd_q[W-2:0], 1'b1};
        end else begin
          pr_d  = shifted_s;
          dvd_d = {dvd_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        if (zero_q) begin
          quo_d = {N{1'b0}};
          rem_d = {N{1'b0}};
          ovf_d = 1'b0;
          dbz_d = 1'b1;
        end else begin
          dbz_d = 1'b0;
          rem_d = dvd_neg_q ? -pr_q[N-1:0] : pr_q[N-1:0];
          if (qs_s > Q_MAX) begin
            quo_d = Q_MAX[N-1:0];
            ovf_d = 1'b1;
          end else if (qs_s < Q_MIN) begin
            quo_d = Q_MIN[N-1:0];
            ovf_d = 1'b1;
          end else begin
            quo_d = qs_s[N-1:0];
            ovf_d = 1'b0;
          end
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dvd_q     <= {W{1'b0}};
      pr_q      <= {(N+1){1'b0}};
      dsr_q     <= {N{1'b0}};
      cnt_q     <= {CW{1'b0}};
      dvd_neg_q <= 1'b0;
      q_neg_q   <= 1'b0;
      zero_q    <= 1'b0;
      quo_q     <= {N{1'b0}};
      rem_q     <= {N{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      pr_q      <= pr_d;
      dsr_q     <= dsr_d;
      cnt_q     <= cnt_d;
      dvd_neg_q <= dvd_neg_d;
      q_neg_q   <= q_neg_d;
      zero_q    <= zero_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
    end
  end

  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.dbz  = dbz_q;
endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (DATAWIDTH=8): signs, saturation,
// divide by zero, ignored start, back-to-back requests and reset abort.
module tb_seq_div;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seq_div_if #(.DATAWIDTH(8)) bus ();

  seq_div #(.DATAWIDTH(8)) dut (
    .Clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start pulse from the current negedge; returns one negedge after the sampling edge.
  task automatic issue(input logic signed [15:0] a, input logic signed [7:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'h5A5A;
    bus.divisor  = 8'h00;
  endtask

  // Counts edges until done (bounded) and the busy samples seen on the way.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.quo, bus.rem, bus.busy, bus.done, bus.ovf, bus.dbz} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_state: got %h required 00000",
               {bus.quo, bus.rem, bus.busy, bus.done, bus.ovf, bus.dbz});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int busy_n;
    issue(-16'sd15, 8'sd3);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic_latency: got %0d required 17", lat);
    end
    checks++;
    if (busy_n !== 17) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d required 17", busy_n);
    end
    checks++;
    if ({bus.quo, bus.rem, bus.ovf, bus.dbz} !== {-8'sd5, 8'sd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: quo=%0d rem=%0d ovf=%b dbz=%b required -5 0 0 0",
               bus.quo, bus.rem, bus.ovf, bus.dbz);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_drop: done=%b busy=%b required 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_signs_and_overflow();
    logic signed [15:0] a  [7] = '{16'sd100, -16'sd100, -16'sd100, 16'sd16384, 16'sd1000, -16'sd32768, -16'sd1000};
    logic signed [7:0]  b  [7] = '{-8'sd7, 8'sd7, -8'sd7, -8'sd128, 8'sd3, -8'sd1, 8'sd3};
    logic signed [7:0]  eq [7] = '{-8'sd14, -8'sd14, 8'sd14, -8'sd128, 8'sd127, 8'sd127, -8'sd128};
    logic signed [7:0]  er [7] = '{8'sd2, -8'sd2, -8'sd2, 8'sd0, 8'sd1, 8'sd0, -8'sd1};
    logic               eo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat;
    int busy_n;
    for (int i = 0; i < 7; i++) begin
      issue(a[i], b[i]);
      wait_done(lat, busy_n);
      checks++;
      if (lat !== 17 || {bus.quo, bus.rem, bus.ovf, bus.dbz} !== {eq[i], er[i], eo[i], 1'b0}) begin
        errors++;
        $display("FAIL div_%0d_by_%0d: lat=%0d quo=%0d rem=%0d ovf=%b dbz=%b required lat=17 quo=%0d rem=%0d ovf=%b dbz=0",
                 a[i], b[i], lat, bus.quo, bus.rem, bus.ovf, bus.dbz, eq[i], er[i], eo[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    int busy_n;
    issue(16'sd55, 8'sd0);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 17 || {bus.quo, bus.rem, bus.ovf, bus.dbz} !== {8'sd0, 8'sd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL dbz_result: lat=%0d quo=%0d rem=%0d ovf=%b dbz=%b required lat=17 0 0 0 1",
               lat, bus.quo, bus.rem, bus.ovf, bus.dbz);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.quo, bus.rem, bus.ovf, bus.dbz, bus.done} !== {8'sd0, 8'sd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL dbz_hold: quo=%0d rem=%0d ovf=%b dbz=%b done=%b required 0 0 0 1 0",
               bus.quo, bus.rem, bus.ovf, bus.dbz, bus.done);
    end
    issue(16'sd9, 8'sd2);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 17 || {bus.quo, bus.rem, bus.ovf, bus.dbz} !== {8'sd4, 8'sd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_dbz_9_by_2: lat=%0d quo=%0d rem=%0d ovf=%b dbz=%b required lat=17 4 1 0 0",
               lat, bus.quo, bus.rem, bus.ovf, bus.dbz);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int lat;
    int busy_n;
    issue(16'sd200, 8'sd10);
    repeat (4) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 16'sd7;
    bus.divisor  = 8'sd7;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done(lat, busy_n);
    checks++;
    if (lat + 5 !== 17 || {bus.quo, bus.rem, bus.ovf, bus.dbz} !== {8'sd20, 8'sd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL start_while_busy: lat=%0d quo=%0d rem=%0d ovf=%b dbz=%b required lat=17 20 0 0 0",
               lat + 5, bus.quo, bus.rem, bus.ovf, bus.dbz);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int busy_n;
    issue(16'sd84, 8'sd4);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 17 || {bus.quo, bus.rem} !== {8'sd21, 8'sd0}) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d quo=%0d rem=%0d required lat=17 21 0", lat, bus.quo, bus.rem);
    end
    issue(16'sd13, -8'sd4);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 17 || {bus.quo, bus.rem, bus.ovf, bus.dbz} !== {-8'sd3, 8'sd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d quo=%0d rem=%0d ovf=%b dbz=%b required lat=17 -3 1 0 0",
               lat, bus.quo, bus.rem, bus.ovf, bus.dbz);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat;
    int busy_n;
    int stale;
    issue(16'sd200, 8'sd10);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.quo, bus.rem, bus.busy, bus.done, bus.ovf, bus.dbz} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_abort_state: got %h required 00000",
               {bus.quo, bus.rem, bus.busy, bus.done, bus.ovf, bus.dbz});
    end
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL reset_abort_stale_done: %0d cycles with done/busy required 0", stale);
    end
    issue(16'sd50, -8'sd5);
    wait_done(lat, busy_n);
    checks++;
    if (lat !== 17 || {bus.quo, bus.rem, bus.ovf, bus.dbz} !== {-8'sd10, 8'sd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_50_by_m5: lat=%0d quo=%0d rem=%0d ovf=%b dbz=%b required lat=17 -10 0 0 0",
               lat, bus.quo, bus.rem, bus.ovf, bus.dbz);
    end
    @(negedge clk);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'h0000;
    bus.divisor  = 8'h00;
    test_reset();
    test_basic();
    test_signs_and_overflow();
    test_div_by_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
